// File: rtl/mems_scan_sequencer.sv
// mems_scan_sequencer -- init command sequence followed by a programmable raster scan,
// issuing one-cycle start strobes and ROM addresses to the MEMS DAC SPI master. rev 1.0
`default_nettype none

module mems_scan_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int INIT_LEN  = 2,
  parameter int SCAN_BASE = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mems_soft_reset,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_mode,
  input  logic [CNT_W-1:0]  line_len,
  input  logic [CNT_W-1:0]  lines_per_frame,
  input  logic              mems_SPI_busy,
  input  logic              new_line_FIFO_done,
  input  logic              new_frame_FIFO_done,
  output logic              mems_SPI_start,
  output logic [ADDR_W-1:0] addr,
  output logic              new_line,
  output logic              new_frame,
  output logic              overrun,
  output logic              scan_done,
  output logic [CNT_W-1:0]  line_num
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [ADDR_W-1:0] INIT_LAST_ADDR = ADDR_W'(INIT_LEN - 1);
  localparam logic [ADDR_W-1:0] SCAN_BASE_ADDR = ADDR_W'(SCAN_BASE);

  logic [1:0]        state_q, state_d;
  logic              start_q, start_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              new_line_q, new_line_d;
  logic              new_frame_q, new_frame_d;
  logic              overrun_q, overrun_d;
  logic              scan_done_q, scan_done_d;
  logic [CNT_W-1:0]  line_num_q, line_num_d;
  logic [CNT_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  line_q, line_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  lpf_q, lpf_d;

  logic              issue_ok;
  logic              scan_issue;
  logic              col_last;
  logic              frame_last;
  logic [CNT_W-1:0]  len_eff;
  logic [CNT_W-1:0]  lpf_eff;

  // Not being mid-strobe guarantees an idle cycle between consecutive strobes.
  assign issue_ok   = !mems_SPI_busy && !start_q;
  assign len_eff    = (line_len == '0) ? CNT_W'(1) : line_len;
  assign lpf_eff    = (lines_per_frame == '0) ? CNT_W'(1) : lines_per_frame;
  assign col_last   = (col_q == len_q - CNT_W'(1));
  assign frame_last = col_last && (line_q == lpf_q - CNT_W'(1));

  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    addr_d      = addr_q;
    scan_done_d = 1'b0;
    line_num_d  = line_num_q;
    col_d       = col_q;
    line_d      = line_q;
    len_d       = len_q;
    lpf_d       = lpf_q;
    overrun_d   = overrun_q;
    new_line_d  = new_line_q && !new_line_FIFO_done;
    new_frame_d = new_frame_q && !new_frame_FIFO_done;
    scan_issue  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (mems_soft_reset) begin
          start_d   = 1'b1;
          addr_d    = '0;
          state_d   = ST_INIT;
          overrun_d = 1'b0;
        end
      end
      ST_INIT: begin
        if (issue_ok) begin
          start_d = 1'b1;
          if (addr_q == INIT_LAST_ADDR) begin
            addr_d     = SCAN_BASE_ADDR;
            state_d    = ST_SCAN;
            len_d      = len_eff;
            lpf_d      = lpf_eff;
            col_d      = '0;
            line_d     = '0;
            scan_issue = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      ST_SCAN: begin
        if (issue_ok) begin
          if (stop) begin
            state_d     = ST_DONE;
            scan_done_d = 1'b1;
          end else if (pause) begin
            state_d = ST_SCAN;
          end else if (frame_last) begin
            if (loop_mode) begin
              start_d    = 1'b1;
              addr_d     = SCAN_BASE_ADDR;
              len_d      = len_eff;
              lpf_d      = lpf_eff;
              col_d      = '0;
              line_d     = '0;
              scan_issue = 1'b1;
            end else begin
              state_d     = ST_DONE;
              scan_done_d = 1'b1;
            end
          end else begin
            start_d    = 1'b1;
            addr_d     = addr_q + ADDR_W'(1);
            scan_issue = 1'b1;
            if (col_last) begin
              col_d  = '0;
              line_d = line_q + CNT_W'(1);
            end else begin
              col_d = col_q + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Boundary flags follow the point being issued now; a set beats a same-cycle clear.
    if (scan_issue) begin
      line_num_d = line_d;
      if (col_d == len_d - CNT_W'(1)) begin
        if (line_d == lpf_d - CNT_W'(1)) begin
          if (new_frame_q) overrun_d = 1'b1;
          new_frame_d = 1'b1;
        end else begin
          if (new_line_q) overrun_d = 1'b1;
          new_line_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      addr_q      <= '0;
      new_line_q  <= 1'b0;
      new_frame_q <= 1'b0;
      overrun_q   <= 1'b0;
      scan_done_q <= 1'b0;
      line_num_q  <= '0;
      col_q       <= '0;
      line_q      <= '0;
      len_q       <= '0;
      lpf_q       <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      addr_q      <= addr_d;
      new_line_q  <= new_line_d;
      new_frame_q <= new_frame_d;
      overrun_q   <= overrun_d;
      scan_done_q <= scan_done_d;
      line_num_q  <= line_num_d;
      col_q       <= col_d;
      line_q      <= line_d;
      len_q       <= len_d;
      lpf_q       <= lpf_d;
    end
  end

  assign mems_SPI_start = start_q;
  assign addr           = addr_q;
  assign new_line       = new_line_q;
  assign new_frame      = new_frame_q;
  assign overrun        = overrun_q;
  assign scan_done      = scan_done_q;
  assign line_num       = line_num_q;

endmodule

`default_nettype wire

// File: tb/tb_mems_scan_sequencer.sv
// tb_mems_scan_sequencer -- directed stimulus with a flat-index behavioural model and literal checks. rev 1.0
`default_nettype none

module tb_mems_scan_sequencer;

  localparam int ADDR_W    = 16;
  localparam int INIT_LEN  = 2;
  localparam int SCAN_BASE = 8;
  localparam int CNT_W     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              mems_soft_reset, pause, stop, loop_mode, mems_SPI_busy;
  logic [CNT_W-1:0]  line_len, lines_per_frame;
  logic              new_line_FIFO_done = 1'b0;
  logic              new_frame_FIFO_done = 1'b0;
  logic              mems_SPI_start, new_line, new_frame, overrun, scan_done;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  line_num;

  mems_scan_sequencer #(
    .ADDR_W(ADDR_W), .INIT_LEN(INIT_LEN), .SCAN_BASE(SCAN_BASE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .mems_soft_reset(mems_soft_reset), .pause(pause), .stop(stop),
    .loop_mode(loop_mode), .line_len(line_len), .lines_per_frame(lines_per_frame),
    .mems_SPI_busy(mems_SPI_busy), .new_line_FIFO_done(new_line_FIFO_done),
    .new_frame_FIFO_done(new_frame_FIFO_done), .mems_SPI_start(mems_SPI_start), .addr(addr),
    .new_line(new_line), .new_frame(new_frame), .overrun(overrun), .scan_done(scan_done),
    .line_num(line_num)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  wire [36:0] dut_vec = {mems_SPI_start, addr, new_line, new_frame, overrun, scan_done, line_num};

  // Model: scan position is a flat point index p within the frame (L points/line, F lines).
  int    m_state;  // 0 idle, 1 init, 2 scan, 3 done
  bit    m_start, m_nl, m_nf, m_ovr, m_done, opp, iss, n_nl, n_nf, n_ovr;
  int    m_addr;
  longint m_p, m_L, m_F, m_ln;
  wire [36:0] mdl_vec = {m_start, 16'(m_addr), m_nl, m_nf, m_ovr, m_done, 16'(m_ln)};

  int q_addr[$];
  int q_cyc[$];
  bit q_nl[$];
  bit q_nf[$];
  int q_ln[$];
  int cyc = 0;
  int done_cnt = 0;

  function automatic longint eff(input logic [CNT_W-1:0] v);
    return (v == 0) ? 1 : longint'(v);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_start = 0; m_addr = 0; m_nl = 0; m_nf = 0; m_ovr = 0;
      m_done = 0; m_ln = 0; m_p = 0; m_L = 1; m_F = 1;
    end else begin
      opp   = !mems_SPI_busy && !m_start;
      iss   = 0;
      n_nl  = m_nl && !new_line_FIFO_done;
      n_nf  = m_nf && !new_frame_FIFO_done;
      n_ovr = m_ovr;
      m_done  = 0;
      m_start = 0;
      case (m_state)
        0, 3: if (mems_soft_reset) begin
          m_start = 1; m_addr = 0; m_state = 1; n_ovr = 0;
        end
        1: if (opp) begin
          m_start = 1;
          if (m_addr == INIT_LEN - 1) begin
            m_L = eff(line_len); m_F = eff(lines_per_frame); m_p = 0; m_state = 2; iss = 1;
          end else m_addr = m_addr + 1;
        end
        2: if (opp) begin
          if (stop) begin
            m_state = 3; m_done = 1;
          end else if (!pause) begin
            if (m_p == m_L * m_F - 1) begin
              if (loop_mode) begin
                m_L = eff(line_len); m_F = eff(lines_per_frame); m_p = 0; iss = 1; m_start = 1;
              end else begin
                m_state = 3; m_done = 1;
              end
            end else begin
              m_p = m_p + 1; iss = 1; m_start = 1;
            end
          end
        end
        default: m_state = 0;
      endcase
      if (iss) begin
        m_addr = (SCAN_BASE + int'(m_p)) % 65536;
        m_ln   = m_p / m_L;
        if (m_p == m_L * m_F - 1) begin
          if (m_nf) n_ovr = 1;
          n_nf = 1;
        end else if (m_p % m_L == m_L - 1) begin
          if (m_nl) n_ovr = 1;
          n_nl = 1;
        end
      end
      m_nl = n_nl; m_nf = n_nf; m_ovr = n_ovr;
    end
    #1;
    chk("outputs_vs_model", 64'(dut_vec), 64'(mdl_vec));
    if (mems_SPI_start) begin
      q_addr.push_back(int'(addr)); q_cyc.push_back(cyc);
      q_nl.push_back(new_line); q_nf.push_back(new_frame); q_ln.push_back(int'(line_num));
    end
    if (scan_done) done_cnt++;
    cyc++;
  end

  // FIFO-side acknowledge: clears a flag the cycle after it is seen, unless disabled.
  bit ack_en = 1'b1;
  bit force_nl = 1'b0;
  always @(negedge clk) begin
    new_line_FIFO_done  = (ack_en && new_line) || force_nl;
    new_frame_FIFO_done = ack_en && new_frame;
  end

  task automatic wait_strobe(input int a, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (mems_SPI_start && int'(addr) == a) ok = 1;
    end
  endtask

  task automatic pulse_soft_reset();
    mems_soft_reset = 1'b1;
    @(negedge clk);
    mems_soft_reset = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int base;
  bit ok;
  int exp_addr1[16] = '{0, 1, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 8, 9};
  bit exp_nl1[16]   = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
  bit exp_nf1[16]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

  initial begin
    rst = 1'b1; mems_soft_reset = 0; pause = 0; stop = 0; loop_mode = 1; mems_SPI_busy = 0;
    line_len = 4; lines_per_frame = 3;
    repeat (3) @(negedge clk);
    chk("reset_state", 64'(dut_vec), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Looping raster: addresses, spacing, boundary flags, line numbers.
    base = q_addr.size();
    pulse_soft_reset();
    chk("first_strobe", {63'd0, mems_SPI_start} << 16 | 64'(addr), 64'h1_0000);
    repeat (34) @(negedge clk);
    chk("loop_strobe_count_ge16", 64'(q_addr.size() - base >= 16), 64'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("loop_addr[%0d]", i), 64'(q_addr[base + i]), 64'(exp_addr1[i]));
      chk($sformatf("loop_new_line[%0d]", i), 64'(q_nl[base + i]), 64'(exp_nl1[i]));
      chk($sformatf("loop_new_frame[%0d]", i), 64'(q_nf[base + i]), 64'(exp_nf1[i]));
      if (i > 0) chk($sformatf("loop_spacing[%0d]", i), 64'(q_cyc[base + i] - q_cyc[base + i - 1]), 64'd2);
    end
    chk("line_num_at_8", 64'(q_ln[base + 2]), 64'd0);
    chk("line_num_at_12", 64'(q_ln[base + 6]), 64'd1);
    chk("line_num_at_16", 64'(q_ln[base + 10]), 64'd2);
    chk("line_num_at_wrap8", 64'(q_ln[base + 14]), 64'd0);

    // Single frame: stops after addr 19, one scan_done, restart at addr 0.
    do_reset();
    loop_mode = 0;
    done_cnt = 0;
    base = q_addr.size();
    pulse_soft_reset();
    repeat (40) @(negedge clk);
    chk("single_strobe_count", 64'(q_addr.size() - base), 64'd14);
    chk("single_last_addr", 64'(q_addr[q_addr.size() - 1]), 64'd19);
    chk("single_done_pulses", 64'(done_cnt), 64'd1);
    pulse_soft_reset();
    chk("restart_from_done", {63'd0, mems_SPI_start} << 16 | 64'(addr), 64'h1_0000);
    loop_mode = 1;

    // Overrun: no acknowledge; clear coincides with the addr-15 boundary.
    do_reset();
    ack_en = 1'b0;
    pulse_soft_reset();
    wait_strobe(11, 40, ok);
    chk("ovr_saw_addr11", 64'(ok), 64'd1);
    chk("ovr_new_line_at_11", 64'(new_line), 64'd1);
    wait_strobe(14, 20, ok);
    chk("ovr_saw_addr14", 64'(ok), 64'd1);
    #1 force_nl = 1'b1;
    @(negedge clk);
    #1 force_nl = 1'b0;
    @(negedge clk);
    chk("set_beats_clear", {62'd0, mems_SPI_start, new_line} << 16 | 64'(addr), 64'h3_000F);
    wait_strobe(11, 40, ok);
    chk("ovr_saw_second_11", 64'(ok), 64'd1);
    chk("overrun_set", 64'(overrun), 64'd1);
    stop = 1'b1;
    repeat (4) @(negedge clk);
    stop = 1'b0;
    pulse_soft_reset();
    chk("overrun_cleared_on_restart", {61'd0, mems_SPI_start, overrun, new_line} << 16 | 64'(addr), 64'h5_0000);
    ack_en = 1'b1;

    // Pause and busy holds mid-line.
    wait_strobe(10, 40, ok);
    chk("pause_saw_addr10", 64'(ok), 64'd1);
    pause = 1'b1;
    base = q_addr.size();
    repeat (10) @(negedge clk);
    pause = 1'b0;
    chk("no_strobe_while_paused", 64'(q_addr.size() - base), 64'd0);
    wait_strobe(11, 4, ok);
    chk("resume_after_pause_11", 64'(ok), 64'd1);
    mems_SPI_busy = 1'b1;
    base = q_addr.size();
    repeat (5) @(negedge clk);
    mems_SPI_busy = 1'b0;
    chk("no_strobe_while_busy", 64'(q_addr.size() - base), 64'd0);
    wait_strobe(12, 4, ok);
    chk("resume_after_busy_12", 64'(ok), 64'd1);

    // Pause ignored during INIT, then holds on the first scan point.
    do_reset();
    pause = 1'b1;
    base = q_addr.size();
    pulse_soft_reset();
    repeat (20) @(negedge clk);
    chk("pause_init_count", 64'(q_addr.size() - base), 64'd3);
    chk("pause_init_a0", 64'(q_addr[base]), 64'd0);
    chk("pause_init_a1", 64'(q_addr[base + 1]), 64'd1);
    chk("pause_init_a2", 64'(q_addr[base + 2]), 64'd8);

    // Stop mid-frame.
    pause = 1'b0;
    wait_strobe(13, 30, ok);
    chk("stop_saw_addr13", 64'(ok), 64'd1);
    stop = 1'b1;
    done_cnt = 0;
    base = q_addr.size();
    repeat (20) @(negedge clk);
    stop = 1'b0;
    chk("stop_no_strobe", 64'(q_addr.size() - base), 64'd0);
    chk("stop_done_pulses", 64'(done_cnt), 64'd1);

    // Reset while busy in SCAN.
    pulse_soft_reset();
    wait_strobe(9, 30, ok);
    chk("rst_saw_addr9", 64'(ok), 64'd1);
    mems_SPI_busy = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_mid_scan", 64'(dut_vec), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mems_SPI_busy = 1'b0;

    // Zero lengths behave as 1x1 frames: every point ends the frame.
    line_len = 0;
    lines_per_frame = 0;
    base = q_addr.size();
    pulse_soft_reset();
    repeat (12) @(negedge clk);
    chk("zero_len_a2", 64'(q_addr[base + 2]), 64'd8);
    chk("zero_len_a3", 64'(q_addr[base + 3]), 64'd8);
    chk("zero_len_a4", 64'(q_addr[base + 4]), 64'd8);
    chk("zero_len_nf", {62'd0, q_nf[base + 3], q_nl[base + 3]}, 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
